booth_acc: RTL and testbench



---
 rtl/booth_acc.sv | 156 +++++++++++++++
 tb/tb_booth_acc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_acc.sv
// Sequencer/accumulator around a radix-2 Booth multiplier: takes signed operand
// pairs, runs one multiplication at a time, sums the products and emits the sum per frame.
module booth_acc #(
    parameter int Nb   = 2,
    parameter int n    = 2 ** Nb,
    parameter int ACCW = 2 * n + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [n-1:0]      in_a,
    input  logic [n-1:0]      in_b,
    input  logic              in_last,
    output logic              mul_ld,
    output logic [n-1:0]      mul_im,
    output logic [n-1:0]      mul_iq,
    input  logic              mul_pd,
    input  logic [2*n-1:0]    mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACCW-1:0]   out_acc,
    output logic              ovf,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam int             WDW      = $clog2(n + 2);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(n + 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_capture;
    logic            w_timeout;
    logic [WDW-1:0]  r_wd;
    logic [n-1:0]    r_a;
    logic [n-1:0]    r_b;
    logic            r_last;
    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] w_addend;
    logic [ACCW-1:0] w_sum;
    logic            r_ovf;
    logic            r_err;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_mul_ld;

    // Signed overflow of a two's-complement addition: same-sign operands, flipped result sign.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
        add_ovf = (sa == sb) && (ss != sa);
    endfunction

    // Next-state decode; mul_pd only matters while waiting for the product.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_pd) begin
                    w_capture   = 1'b1;
                    w_state_nxt = r_last ? S_OUT : S_IDLE;
                end else if (r_wd == WD_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = r_last ? S_OUT : S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A watchdog expiry contributes a zero product.
    always_comb begin
        w_addend = w_capture ? ACCW'($signed(mul_p)) : {ACCW{1'b0}};
        w_sum    = r_acc + w_addend;
    end

    // State, operand, accumulator and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wd        <= {WDW{1'b0}};
            r_a         <= {n{1'b0}};
            r_b         <= {n{1'b0}};
            r_last      <= 1'b0;
            r_acc       <= {ACCW{1'b0}};
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_mul_ld    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_OUT);
            r_mul_ld    <= (w_state_nxt == S_LOAD);
            if (r_state == S_IDLE && in_valid) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_last <= in_last;
            end
            if (r_state == S_WAIT) begin
                r_wd <= r_wd + WDW'(1);
            end else begin
                r_wd <= {WDW{1'b0}};
            end
            if (w_capture) begin
                r_acc <= w_sum;
                if (add_ovf(r_acc[ACCW-1], w_addend[ACCW-1], w_sum[ACCW-1])) begin
                    r_ovf <= 1'b1;
                end
            end else if (r_state == S_OUT && out_ready) begin
                r_acc <= {ACCW{1'b0}};
                r_ovf <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign mul_ld    = r_mul_ld;
    assign mul_im    = r_a;
    assign mul_iq    = r_b;
    assign out_acc   = r_acc;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule

// File: tb/tb_booth_acc.sv
// Self-checking bench for booth_acc: a behavioural multiplier model answers mul_ld,
// and an arithmetic reference tracks the frame sum, overflow and watchdog error.
module tb_booth_acc;
    localparam int NB   = 2;
    localparam int N    = 4;
    localparam int ACCW = 10;
    localparam int STALL = 99;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_a;
    logic [N-1:0]    in_b;
    logic            in_last;
    logic            mul_ld;
    logic [N-1:0]    mul_im;
    logic [N-1:0]    mul_iq;
    logic            mul_pd;
    logic [2*N-1:0]  mul_p;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_acc;
    logic            ovf;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_acc  = 0;
    bit exp_ovf  = 1'b0;
    bit exp_err  = 1'b0;

    booth_acc #(.Nb(NB), .n(N), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_ld(mul_ld), .mul_im(mul_im), .mul_iq(mul_iq), .mul_pd(mul_pd), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACCW-1:0] acc_bits();
        int v;
        v = exp_acc;
        return v[ACCW-1:0];
    endfunction

    // Reference: integer sum, overflow when the true sum leaves the signed range.
    task automatic model_add(input int p);
        int s;
        s = exp_acc + p;
        if (s > 511 || s < -512) exp_ovf = 1'b1;
        if (s > 511) s -= 1024;
        if (s < -512) s += 1024;
        exp_acc = s;
    endtask

    // Send one pair; the multiplier model raises pd in WAIT cycle d (STALL = never).
    task automatic send_pair(input int a, input int b, input bit last, input int d, input bit spur);
        int cyc;
        int p;
        logic [N-1:0] av;
        logic [N-1:0] bv;
        av = a[N-1:0];
        bv = b[N-1:0];
        p  = a * b;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("in_ready_idle", in_ready, 1);
        chk("mul_ld_idle", mul_ld, 0);
        in_valid = 1'b1; in_a = av; in_b = bv; in_last = last;
        tick();
        in_valid = 1'b0; in_a = 4'($urandom); in_b = 4'($urandom);
        chk("mul_ld_load", mul_ld, 1);
        chk("mul_im", mul_im, av);
        chk("mul_iq", mul_iq, bv);
        if (spur) begin
            mul_pd = 1'b1;
            mul_p  = 8'($urandom);
        end
        tick();
        mul_pd = 1'b0;
        chk("mul_ld_wait", mul_ld, 0);
        for (int w = 0; w <= N + 1; w++) begin
            chk("in_ready_busy", in_ready, 0);
            if (w == d) begin
                mul_pd = 1'b1;
                mul_p  = p[2*N-1:0];
            end else begin
                mul_p = 8'($urandom);
            end
            tick();
            mul_pd = 1'b0;
            mul_p  = 8'($urandom);
            if (w == d) break;
        end
        if (d > N + 1) exp_err = 1'b1;
        else model_add(p);
        chk("acc", out_acc, acc_bits());
        chk("ovf", ovf, exp_ovf);
        chk("err", err, exp_err);
        chk("out_valid_done", out_valid, last);
        chk("in_ready_done", in_ready, !last);
    endtask

    task automatic take_output(input int stall);
        chk("out_valid", out_valid, 1);
        chk("out_acc", out_acc, acc_bits());
        chk("out_ovf", ovf, exp_ovf);
        chk("out_err", err, exp_err);
        for (int i = 0; i < stall; i++) begin
            in_valid  = i[0];
            out_ready = 1'b0;
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_acc", out_acc, acc_bits());
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_acc = 0;
        exp_ovf = 1'b0;
        chk("acc_after_out", out_acc, 0);
        chk("ovf_after_out", ovf, 0);
        chk("out_valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    task automatic spur_idle();
        mul_pd = 1'b1;
        mul_p  = 8'($urandom);
        tick();
        mul_pd = 1'b0;
        chk("spur_idle_acc", out_acc, acc_bits());
        chk("spur_idle_rdy", in_ready, 1);
    endtask

    initial begin
        int len;
        int a;
        int b;
        int d;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        mul_pd = 1'b0; mul_p = '0; out_ready = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mul_ld", mul_ld, 0);
        chk("rst_mul_im", mul_im, 0);
        chk("rst_mul_iq", mul_iq, 0);
        chk("rst_acc", out_acc, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // Single pair -> -6
        send_pair(3, -2, 1'b1, N, 1'b0);
        take_output(0);
        // Frame of three -> 51
        send_pair(3, 5, 1'b0, N, 1'b0);
        send_pair(-4, 7, 1'b0, N, 1'b0);
        send_pair(-8, -8, 1'b1, N, 1'b0);
        take_output(0);
        // Overflow: eight (-8,-8) wraps to -512
        for (int i = 0; i < 8; i++) send_pair(-8, -8, i == 7, N, 1'b0);
        chk("ovf_wrap_acc", out_acc, 10'h200);
        take_output(5);
        // Spurious pd in IDLE and LOAD, then normal capture
        send_pair(7, 7, 1'b0, N, 1'b0);
        spur_idle();
        send_pair(2, -3, 1'b1, N, 1'b1);
        take_output(2);
        // Late pd at WAIT cycle n+1 is still a product
        send_pair(-5, 3, 1'b1, N + 1, 1'b0);
        take_output(0);
        // Random frames
        for (int f = 0; f < 8; f++) begin
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                a = int'($urandom_range(0, 15)) - 8;
                b = int'($urandom_range(0, 15)) - 8;
                d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N + 1)) : N;
                send_pair(a, b, i == len - 1, d, $urandom_range(0, 1) == 1);
            end
            take_output(int'($urandom_range(0, 3)));
        end
        // Stalled multiplier: err sticks, product counted as zero
        send_pair(3, 3, 1'b0, STALL, 1'b0);
        send_pair(2, 2, 1'b1, N, 1'b0);
        take_output(1);
        chk("err_sticky", err, 1);
        // Reset mid-WAIT, then a late pd from the multiplier is ignored
        in_valid = 1'b1; in_a = 4'd5; in_b = 4'd3; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_acc = 0; exp_ovf = 1'b0; exp_err = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_acc", out_acc, 0);
        chk("midrst_err", err, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mul_im", mul_im, 0);
        mul_pd = 1'b1; mul_p = 8'h0F;
        tick();
        mul_pd = 1'b0;
        chk("late_pd_acc", out_acc, 0);
        send_pair(-7, 6, 1'b1, N, 1'b0);
        take_output(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
